// File: rtl/level_controller.sv
// Game-progress sequencer: idle, per-level intro banner, play, clear/hit pauses, game-over and win.
// Pauses are counted in video frames (startOfFrame pulses), not clocks; all outputs are registered.
module level_controller #(
    parameter int unsigned MAX_LEVEL    = 12,
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned INTRO_FRAMES = 90,
    parameter int unsigned CLEAR_FRAMES = 60,
    parameter int unsigned HIT_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       allBallsPopped,
    input  logic       playerHit,
    output logic [3:0] levelState,
    output logic [2:0] lives,
    output logic       loadLevel,
    output logic       playEnable,
    output logic       showBanner,
    output logic       gameOver,
    output logic       gameWon
);

    typedef enum logic [2:0] {
        StIdle,
        StIntro,
        StPlay,
        StHit,
        StClear,
        StGameOver,
        StWin
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] level_q, level_d;
    logic [2:0] lives_q, lives_d;
    logic       load_q, load_d;
    logic       play_q, banner_q, over_q, won_q;

    logic [8:0] frames_seen;
    logic [7:0] frame_inc;

    // frames_seen is the count including the current pulse; the stored count saturates at 255
    always_comb begin
        frames_seen = {1'b0, frame_cnt_q} + 9'd1;
        frame_inc   = (frame_cnt_q == 8'hff) ? frame_cnt_q : frames_seen[7:0];
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        lives_d     = lives_q;
        load_d      = 1'b0;

        unique case (state_q)
            StIdle, StGameOver, StWin: begin
                if (startGame) begin
                    state_d     = StIntro;
                    level_d     = 4'd1;
                    lives_d     = 3'(START_LIVES);
                    load_d      = 1'b1;
                    frame_cnt_d = 8'd0;
                end
            end
            StIntro: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_inc;
                    if (frames_seen == 9'(INTRO_FRAMES)) begin
                        state_d     = StPlay;
                        frame_cnt_d = 8'd0;
                    end
                end
            end
            StPlay: begin
                // A hit outranks a simultaneous clear
                if (playerHit) begin
                    frame_cnt_d = 8'd0;
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = StHit;
                    end else begin
                        lives_d = 3'd0;
                        state_d = StGameOver;
                    end
                end else if (allBallsPopped) begin
                    state_d     = StClear;
                    frame_cnt_d = 8'd0;
                end
            end
            StHit: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_inc;
                    if (frames_seen == 9'(HIT_FRAMES)) begin
                        state_d     = StIntro;
                        load_d      = 1'b1;
                        frame_cnt_d = 8'd0;
                    end
                end
            end
            StClear: begin
                if (startOfFrame) begin
                    frame_cnt_d = frame_inc;
                    if (frames_seen == 9'(CLEAR_FRAMES)) begin
                        frame_cnt_d = 8'd0;
                        if (level_q < 4'(MAX_LEVEL)) begin
                            level_d = level_q + 4'd1;
                            load_d  = 1'b1;
                            state_d = StIntro;
                        end else begin
                            state_d = StWin;
                        end
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                frame_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_cnt_q <= 8'd0;
            level_q     <= 4'd0;
            lives_q     <= 3'(START_LIVES);
            load_q      <= 1'b0;
            play_q      <= 1'b0;
            banner_q    <= 1'b0;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            load_q      <= load_d;
            play_q      <= (state_d == StPlay);
            banner_q    <= (state_d == StIntro);
            over_q      <= (state_d == StGameOver);
            won_q       <= (state_d == StWin);
        end
    end

    assign levelState = level_q;
    assign lives      = lives_q;
    assign loadLevel  = load_q;
    assign playEnable = play_q;
    assign showBanner = banner_q;
    assign gameOver   = over_q;
    assign gameWon    = won_q;

endmodule
